// File: rtl/spi_slave_core_if.sv
// SPI pin and word-handshake bundle for spi_slave_core.
// The slave modport is the core's view; master is the host/SPI-master view.
interface spi_slave_core_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_spi_clk;
    logic                  i_spi_mosi;
    logic                  i_spi_ss;
    logic                  o_spi_miso;
    logic [DATA_WIDTH-1:0] i_tx_data;
    logic                  i_tx_valid;
    logic                  o_tx_ready;
    logic [DATA_WIDTH-1:0] o_rx_data;
    logic                  o_rx_valid;
    logic                  o_busy;
    logic                  o_tx_underrun;

    modport slave (
        input  i_spi_clk,
        input  i_spi_mosi,
        input  i_spi_ss,
        output o_spi_miso,
        input  i_tx_data,
        input  i_tx_valid,
        output o_tx_ready,
        output o_rx_data,
        output o_rx_valid,
        output o_busy,
        output o_tx_underrun
    );

    modport master (
        output i_spi_clk,
        output i_spi_mosi,
        output i_spi_ss,
        input  o_spi_miso,
        output i_tx_data,
        output i_tx_valid,
        input  o_tx_ready,
        input  o_rx_data,
        input  o_rx_valid,
        input  o_busy,
        input  o_tx_underrun
    );
endinterface

// File: rtl/spi_slave_core.sv
// Oversampled full-duplex SPI slave: all SPI pins are synchronised to the
// system clock, so no logic runs on SCLK.
module spi_slave_core #(
    parameter int DATA_WIDTH  = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input logic             i_sys_clk,
    input logic             i_rst,
    spi_slave_core_if.slave bus
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DATA_WIDTH);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   ss_prev_q, ss_prev_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]          tx_cnt_q, tx_cnt_d;
    logic [DATA_WIDTH-1:0]  rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic [DATA_WIDTH-1:0]  tx_sh_q, tx_sh_d;
    logic [DATA_WIDTH-1:0]  hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   miso_q, miso_d;
    logic                   underrun_q, underrun_d;

    logic                   sclk_s, ss_s, mosi_s;
    logic                   sclk_rise, sclk_fall;
    logic                   lead_ev, trail_ev;
    logic                   sample_ev, drive_ev;
    logic                   ss_fall, ss_rise;
    logic                   load, drv;
    logic [DATA_WIDTH-1:0]  src;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign lead_ev   = CPOL ? sclk_fall : sclk_rise;
    assign trail_ev  = CPOL ? sclk_rise : sclk_fall;
    assign sample_ev = CPHA ? trail_ev : lead_ev;
    assign drive_ev  = CPHA ? lead_ev : trail_ev;
    assign ss_fall   = ~ss_s & ss_prev_q;
    assign ss_rise   = ss_s & ~ss_prev_q;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.i_spi_clk};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], bus.i_spi_ss};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.i_spi_mosi};
        sclk_prev_d = sclk_s;
        ss_prev_d   = ss_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_cnt_d    = tx_cnt_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_sh_d     = tx_sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        miso_d      = miso_q;
        underrun_d  = 1'b0;
        load        = 1'b0;
        drv         = 1'b0;
        src         = tx_sh_q;

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (ss_fall) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = '0;
                    load      = 1'b1;
                    drv       = !CPHA;
                end
            end
            ACTIVE: begin
                // SS rise takes priority over any SCLK event in the same cycle
                if (ss_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    tx_cnt_d  = '0;
                    miso_d    = 1'b0;
                end else begin
                    if (sample_ev) begin
                        rx_sh_d = MSB_FIRST ?
                            {rx_sh_q[DATA_WIDTH-2:0], mosi_s} :
                            {mosi_s, rx_sh_q[DATA_WIDTH-1:1]};
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d  = '0;
                            rx_data_d  = rx_sh_d;
                            rx_valid_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    if (drive_ev) begin
                        drv  = 1'b1;
                        load = (tx_cnt_q == FULL_CNT);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            src         = hold_full_q ? hold_q : '0;
            underrun_d  = ~hold_full_q;
            hold_full_d = 1'b0;
            tx_sh_d     = src;
            tx_cnt_d    = '0;
        end

        if (drv) begin
            miso_d   = MSB_FIRST ? src[DATA_WIDTH-1] : src[0];
            tx_sh_d  = MSB_FIRST ?
                {src[DATA_WIDTH-2:0], 1'b0} :
                {1'b0, src[DATA_WIDTH-1:1]};
            tx_cnt_d = load ? CW'(1) : tx_cnt_q + 1'b1;
        end

        // Capture after the load so a same-cycle write keeps ready low
        if (bus.i_tx_valid && !hold_full_q) begin
            hold_d      = bus.i_tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            sclk_sync_q <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
            bit_cnt_q   <= '0;
            tx_cnt_q    <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            tx_sh_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            miso_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            ss_prev_q   <= ss_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            tx_sh_q     <= tx_sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_valid_q  <= rx_valid_d;
            miso_q      <= miso_d;
            underrun_q  <= underrun_d;
        end
    end

    assign bus.o_spi_miso    = miso_q;
    assign bus.o_rx_data     = rx_data_q;
    assign bus.o_rx_valid    = rx_valid_q;
    assign bus.o_busy        = (state_q == ACTIVE);
    assign bus.o_tx_ready    = ~hold_full_q;
    assign bus.o_tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: three instances (mode 0 MSB/8, mode 3 MSB/8,
// mode 2 LSB/16) driven by a bit-banged SPI master and a word-level model.
module tb_spi_slave_core;

    localparam int H = 8;

    logic        clk;
    logic        rst;
    logic        sclk[3];
    logic        mosi[3];
    logic        ss[3];
    logic        tx_v[3];
    logic [15:0] tx_d[3];
    logic        miso[3];
    logic        rdy[3];
    logic        rxv[3];
    logic        busy[3];
    logic        urun[3];
    logic [15:0] rxd[3];

    int          rx_cnt[3] = '{0, 0, 0};
    int          ur_cnt[3] = '{0, 0, 0};
    logic [15:0] last_rx[3];
    logic [15:0] feed_mem[3][8];
    int          feed_wr[3] = '{0, 0, 0};
    int          feed_rd[3] = '{0, 0, 0};
    logic [15:0] mo_w[4];
    logic [15:0] sup_w[4];
    int          total = 0;
    int          bad = 0;

    spi_slave_core_if #(.DATA_WIDTH(8))  bus0 ();
    spi_slave_core_if #(.DATA_WIDTH(8))  bus1 ();
    spi_slave_core_if #(.DATA_WIDTH(16)) bus2 ();

    spi_slave_core #(
        .DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0),
        .MSB_FIRST(1'b1), .SYNC_STAGES(2)
    ) u0 (.i_sys_clk(clk), .i_rst(rst), .bus(bus0));

    spi_slave_core #(
        .DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1),
        .MSB_FIRST(1'b1), .SYNC_STAGES(2)
    ) u1 (.i_sys_clk(clk), .i_rst(rst), .bus(bus1));

    spi_slave_core #(
        .DATA_WIDTH(16), .CPOL(1'b1), .CPHA(1'b0),
        .MSB_FIRST(1'b0), .SYNC_STAGES(2)
    ) u2 (.i_sys_clk(clk), .i_rst(rst), .bus(bus2));

    assign bus0.i_spi_clk  = sclk[0];
    assign bus0.i_spi_mosi = mosi[0];
    assign bus0.i_spi_ss   = ss[0];
    assign bus0.i_tx_data  = tx_d[0][7:0];
    assign bus0.i_tx_valid = tx_v[0];
    assign miso[0] = bus0.o_spi_miso;
    assign rdy[0]  = bus0.o_tx_ready;
    assign rxv[0]  = bus0.o_rx_valid;
    assign busy[0] = bus0.o_busy;
    assign urun[0] = bus0.o_tx_underrun;
    assign rxd[0]  = {8'h00, bus0.o_rx_data};

    assign bus1.i_spi_clk  = sclk[1];
    assign bus1.i_spi_mosi = mosi[1];
    assign bus1.i_spi_ss   = ss[1];
    assign bus1.i_tx_data  = tx_d[1][7:0];
    assign bus1.i_tx_valid = tx_v[1];
    assign miso[1] = bus1.o_spi_miso;
    assign rdy[1]  = bus1.o_tx_ready;
    assign rxv[1]  = bus1.o_rx_valid;
    assign busy[1] = bus1.o_busy;
    assign urun[1] = bus1.o_tx_underrun;
    assign rxd[1]  = {8'h00, bus1.o_rx_data};

    assign bus2.i_spi_clk  = sclk[2];
    assign bus2.i_spi_mosi = mosi[2];
    assign bus2.i_spi_ss   = ss[2];
    assign bus2.i_tx_data  = tx_d[2];
    assign bus2.i_tx_valid = tx_v[2];
    assign miso[2] = bus2.o_spi_miso;
    assign rdy[2]  = bus2.o_tx_ready;
    assign rxv[2]  = bus2.o_rx_valid;
    assign busy[2] = bus2.o_busy;
    assign urun[2] = bus2.o_tx_underrun;
    assign rxd[2]  = bus2.o_rx_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Counting high cycles also checks that strobes last exactly one cycle
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rxv[k]) begin
                rx_cnt[k]  <= rx_cnt[k] + 1;
                last_rx[k] <= rxd[k];
            end
            if (urun[k]) ur_cnt[k] <= ur_cnt[k] + 1;
        end
    end

    // Host side: hand queued words to the holding register when it is empty
    initial begin
        for (int k = 0; k < 3; k++) begin
            tx_v[k] = 1'b0;
            tx_d[k] = '0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (tx_v[k]) begin
                    tx_v[k] = 1'b0;
                end else if (feed_rd[k] != feed_wr[k] && rdy[k]) begin
                    tx_d[k] = feed_mem[k][feed_rd[k] % 8];
                    feed_rd[k] = feed_rd[k] + 1;
                    tx_v[k] = 1'b1;
                end
            end
        end
    end

    function automatic int f_w(input int k);
        return (k == 2) ? 16 : 8;
    endfunction

    function automatic logic f_cpol(input int k);
        return (k != 0);
    endfunction

    function automatic logic f_cpha(input int k);
        return (k == 1);
    endfunction

    function automatic logic f_msb(input int k);
        return (k != 2);
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input logic [15:0] w);
        feed_mem[k][feed_wr[k] % 8] = w;
        feed_wr[k] = feed_wr[k] + 1;
    endtask

    // Master: clocks nb bits of one word, returns the bits it sampled
    task automatic xfer(input int k, input int nb, input logic [15:0] mo,
                        output logic [15:0] mi);
        int w;
        int b;
        logic cp;
        logic [15:0] r;
        w  = f_w(k);
        cp = f_cpol(k);
        r  = '0;
        for (int i = 0; i < nb; i++) begin
            b = f_msb(k) ? (w - 1 - i) : i;
            if (!f_cpha(k)) begin
                mosi[k] = mo[b];
                wait_cyc(H);
                sclk[k] = ~cp;
                r[b] = miso[k];
                wait_cyc(H);
                sclk[k] = cp;
            end else begin
                sclk[k] = ~cp;
                mosi[k] = mo[b];
                wait_cyc(H);
                sclk[k] = cp;
                r[b] = miso[k];
                wait_cyc(H);
            end
        end
        mi = r;
    endtask

    // One SS frame of n words. m supply words are queued before SS falls
    // (late=0) or just after (late=1). Every word load pops the supply or
    // yields zero plus an underrun; a frame makes n loads, one more in CPHA=0.
    task automatic frame(input int k, input int n, input int m,
                         input int late, input string tag);
        logic [15:0] mi;
        logic [15:0] exp;
        int r0;
        int u0;
        int loads;
        int idx;
        loads = n + (f_cpha(k) ? 0 : 1);
        r0 = rx_cnt[k];
        u0 = ur_cnt[k];
        if (late == 0) for (int i = 0; i < m; i++) push(k, sup_w[i]);
        wait_cyc(6);
        if (late == 0 && m > 0) chk({tag, "_rdy_full"}, rdy[k], 0);
        ss[k] = 1'b0;
        wait_cyc(H);
        chk({tag, "_busy"}, busy[k], 1);
        if (late == 0) chk({tag, "_rdy_load"}, rdy[k], (m <= 1));
        if (late != 0) for (int i = 0; i < m; i++) push(k, sup_w[i]);
        for (int i = 0; i < n; i++) begin
            xfer(k, f_w(k), mo_w[i], mi);
            idx = i - late;
            exp = (idx >= 0 && idx < m) ? sup_w[idx] : 16'h0000;
            chk({tag, "_miso"}, mi, exp);
            wait_cyc(2);
            chk({tag, "_rxcnt"}, rx_cnt[k] - r0, i + 1);
            chk({tag, "_rxdata"}, last_rx[k], mo_w[i]);
        end
        wait_cyc(H);
        ss[k] = 1'b1;
        wait_cyc(H);
        chk({tag, "_idle"}, busy[k], 0);
        chk({tag, "_miso_idle"}, miso[k], 0);
        chk({tag, "_urun"}, ur_cnt[k] - u0, loads - m);
        chk({tag, "_rxtotal"}, rx_cnt[k] - r0, n);
        chk({tag, "_rdy_end"}, rdy[k], 1);
    endtask

    initial begin : main
        logic [15:0] mi;
        int r0;
        int u0;
        int k;
        int n;
        int m;
        int late;
        int loads;
        logic [15:0] mask;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sclk[i] = f_cpol(i);
            mosi[i] = 1'b0;
            ss[i]   = 1'b1;
        end
        wait_cyc(4);
        chk("rst_miso", miso[0], 0);
        chk("rst_rxdata", rxd[0], 0);
        chk("rst_rxvalid", rxv[0], 0);
        chk("rst_urun", urun[0], 0);
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", rdy[i], 1);
            chk("rst_busy", busy[i], 0);
        end
        rst = 1'b0;
        wait_cyc(4);

        // Mode 0, preloaded 0x3C, receive 0xA5
        mo_w[0] = 16'h00A5;
        sup_w[0] = 16'h003C;
        frame(0, 1, 1, 0, "t1");

        // Mode 3, three back-to-back words
        mo_w[0] = 16'h0011; mo_w[1] = 16'h0022; mo_w[2] = 16'h0033;
        sup_w[0] = 16'h00E1; sup_w[1] = 16'h00E2; sup_w[2] = 16'h00E3;
        frame(1, 3, 3, 0, "t2");

        // 16-bit LSB first
        mo_w[0] = 16'hBEEF;
        sup_w[0] = 16'h1234;
        frame(2, 1, 1, 0, "t3");

        // SS raised after 5 samples, then a full frame
        r0 = rx_cnt[0];
        u0 = ur_cnt[0];
        ss[0] = 1'b0;
        wait_cyc(H);
        xfer(0, 5, 16'h00FF, mi);
        wait_cyc(H);
        ss[0] = 1'b1;
        wait_cyc(H);
        chk("t4_no_strobe", rx_cnt[0] - r0, 0);
        chk("t4_idle", busy[0], 0);
        chk("t4_miso_low", miso[0], 0);
        chk("t4_urun", ur_cnt[0] - u0, 1);
        mo_w[0] = 16'h005A;
        frame(0, 1, 0, 0, "t4");

        // Empty holding at start, word supplied mid-frame
        mo_w[0] = 16'h0081; mo_w[1] = 16'h0042;
        sup_w[0] = 16'h0096;
        frame(0, 2, 1, 1, "t5");

        // Reset at bit 4 with SS held low
        ss[0] = 1'b0;
        wait_cyc(H);
        xfer(0, 4, 16'h00FF, mi);
        rst = 1'b1;
        wait_cyc(1);
        chk("t6_miso", miso[0], 0);
        chk("t6_rxdata", rxd[0], 0);
        chk("t6_rxvalid", rxv[0], 0);
        chk("t6_busy", busy[0], 0);
        chk("t6_ready", rdy[0], 1);
        chk("t6_urun", urun[0], 0);
        rst = 1'b0;
        r0 = rx_cnt[0];
        xfer(0, 8, 16'h003C, mi);
        wait_cyc(H);
        chk("t6_ignored", rx_cnt[0] - r0, 0);
        chk("t6_still_idle", busy[0], 0);
        ss[0] = 1'b1;
        wait_cyc(H);
        mo_w[0] = 16'h00C3;
        frame(0, 1, 0, 0, "t6");

        // Random frames on all three instances
        for (int it = 0; it < 9; it++) begin
            k = it % 3;
            n = $urandom_range(1, 3);
            late = $urandom_range(0, 1);
            loads = n + (f_cpha(k) ? 0 : 1);
            m = $urandom_range(0, loads - late);
            mask = (f_w(k) == 16) ? 16'hFFFF : 16'h00FF;
            for (int i = 0; i < 4; i++) begin
                mo_w[i]  = 16'($urandom) & mask;
                sup_w[i] = 16'($urandom) & mask;
            end
            frame(k, n, m, late, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
Parametrised, full-duplex SPI slave for the synth control path. It receives words of configurable width on MOSI, presents each completed word with a one-cycle valid strobe, and transmits words supplied through a valid/ready holding register on MISO. All four SPI modes and either bit order are supported. SCLK, SS and MOSI are oversampled on the system clock, so the block contains no logic clocked by SCLK.

Parameters:
DATA_WIDTH, 8, bits per SPI word (min 2).
CPOL, 0, SCLK idle level.
CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge.
MSB_FIRST, 1, 1 = MSB shifted first on both MOSI and MISO; 0 = LSB first.
SYNC_STAGES, 2, synchroniser depth on i_spi_clk, i_spi_ss and i_spi_mosi (min 2).

Ports:
i_sys_clk  in  1  system clock
i_rst  in  1  synchronous reset, active high
i_spi_clk  in  1  SPI SCLK (asynchronous)
i_spi_mosi  in  1  SPI MOSI (asynchronous)
i_spi_ss  in  1  SPI slave select, active low (asynchronous)
o_spi_miso  out  1  SPI MISO, registered
i_tx_data  in  DATA_WIDTH  next word to transmit
i_tx_valid  in  1  i_tx_data valid
o_tx_ready  out  1  holding register empty
o_rx_data  out  DATA_WIDTH  last completed received word
o_rx_valid  out  1  one-cycle strobe, o_rx_data updated
o_busy  out  1  frame active (synchronised SS low)
o_tx_underrun  out  1  one-cycle strobe, word load found holding register empty

Behaviour:
- Reset values: o_spi_miso 0, o_rx_data 0, o_rx_valid 0, o_busy 0, o_tx_ready 1, o_tx_underrun 0. Bit counter, shift registers and synchronisers are cleared. The FSM goes to IDLE.
- Synchronisers: each input passes through SYNC_STAGES flops. Edges are detected by comparing the last stage with one extra flop.
- Edge definitions:
  - Leading edge = rising when CPOL=0, falling when CPOL=1. Trailing edge is the opposite.
  - Sample event = leading edge if CPHA=0, trailing edge if CPHA=1.
  - Drive event = trailing edge if CPHA=0, leading edge if CPHA=1.
- Timing requirement: each SCLK high and low phase is at least SYNC_STAGES+2 i_sys_clk cycles. Behaviour is undefined if this is violated.
- FSM IDLE:
  - o_spi_miso is 0 and SCLK edges are ignored.
  - On synchronised SS falling, go to ACTIVE, clear the bit counter and perform a word load.
  - If CPHA=0, the word load also drives the first bit onto o_spi_miso in the same cycle.
- FSM ACTIVE, sample event:
  - Shift the synchronised MOSI into the rx shift register. MSB_FIRST=1 shifts left; MSB_FIRST=0 shifts right.
  - Increment the bit counter.
  - When the counter reaches DATA_WIDTH-1, the next cycle sets o_rx_data to the full word (new bit included) and pulses o_rx_valid for 1 cycle. The counter wraps to 0.
  - Latency: o_rx_valid rises 1 i_sys_clk cycle after the cycle in which the sample edge is detected.
- FSM ACTIVE, drive event:
  - o_spi_miso takes the next tx bit and the tx pointer advances.
  - When all DATA_WIDTH bits of the current word have been driven, perform a word load and drive bit 0 of the new word on this same event.
  - For CPHA=0, the drive event following the last sample of a word drives the first bit of the next word.
- Word load:
  - If the holding register is full, copy it into the tx shift register, mark holding empty, and raise o_tx_ready next cycle.
  - Otherwise load all zeros and pulse o_tx_underrun.
- TX handshake: holding is captured when i_tx_valid && o_tx_ready. If a capture and a word load occur in the same cycle, the load takes the old contents (or zero/underrun if empty), the new word is captured, and o_tx_ready stays 0.
- SS deassert mid-word:
  - Go to IDLE and discard the partial rx word; no o_rx_valid is generated.
  - Clear the bit counter and set o_spi_miso to 0.
  - The unsent tx word is lost; the holding register is untouched.
- SS deassert at a word boundary: no extra strobe is generated.
- Simultaneous SS rise and sample edge in the same cycle: SS wins and the sample is ignored.
- Reset mid-frame returns everything to reset values immediately, regardless of SS. A new frame starts only after SS is seen high and then low again.
- o_busy = (state == ACTIVE).

Test Plan:
1. Mode 0, MSB first, holding preloaded with 0x3C, master sends 0xA5 -> one o_rx_valid pulse with o_rx_data=0xA5; MISO bits seen by master = 0x3C; o_tx_ready rises after the frame-start load.
2. Mode 3 (CPOL=1, CPHA=1), 3 back-to-back words 0x11, 0x22, 0x33 under a single SS low, with tx supplied in time -> three rx_valid pulses in order with matching data; master receives the supplied words; no underrun.
3. MSB_FIRST=0, DATA_WIDTH=16, master sends 0xBEEF LSB first -> o_rx_data=0xBEEF; MISO order is LSB first.
4. SS raised after 5 of 8 sample edges, then a full frame of 0x5A -> no pulse for the partial word; the next frame yields exactly 0x5A; o_spi_miso=0 while SS is high.
5. Empty holding register at frame start -> o_tx_underrun pulses 1 cycle and master reads 0x00. A word written mid-frame is transmitted as the next word.
6. i_rst asserted at bit 4 with SS held low -> all outputs at reset values next cycle; SCLK edges ignored until SS goes high then low; the following frame of 0xC3 is received correctly.
